// File: rtl/main_mem_arbiter.sv
// Two-port arbiter in front of a single-cycle main memory: round-robin grant with
// an optional bounded lock for read-modify-write, plus a 1-deep read return pipe.
module main_mem_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t             state, state_nxt;
    logic               lock_port, lock_port_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic               last_grant;
    logic               rd_valid, rd_port;
    logic               req0, req1, grant0, grant1, grant_any;
    logic               grant_lock, owner_lock, grant_read;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant is forced off during reset so the memory sees no strobes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset_n) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end else if (state == LOCKED) begin
            grant0 = ~lock_port & req0;
            grant1 = lock_port & req1;
        end else if (req0 & req1) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0;
            grant1 = req1;
        end
    end

    assign grant_any  = grant0 | grant1;
    assign grant_lock = grant1 ? m1_lock : (grant0 & m0_lock);
    assign owner_lock = lock_port ? m1_lock : m0_lock;
    assign grant_read = grant1 ? m1_read : (grant0 & m0_read);

    // Lock is released one cycle after the owner drops it, or right after the
    // MAX_LOCK-th consecutive grant so the other port wins the next cycle.
    always_comb begin
        state_nxt     = state;
        lock_port_nxt = lock_port;
        lock_cnt_nxt  = lock_cnt;
        case (state)
            UNLOCKED: begin
                if (grant_any && grant_lock && MAX_LOCK > 1) begin
                    state_nxt     = LOCKED;
                    lock_port_nxt = grant1;
                    lock_cnt_nxt  = CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!owner_lock) begin
                    state_nxt    = UNLOCKED;
                    lock_cnt_nxt = '0;
                end else if (grant_any) begin
                    if (lock_cnt >= CNT_W'(MAX_LOCK - 1)) begin
                        state_nxt    = UNLOCKED;
                        lock_cnt_nxt = '0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= UNLOCKED;
            lock_port  <= 1'b0;
            lock_cnt   <= '0;
            last_grant <= 1'b1;
            rd_valid   <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_port <= lock_port_nxt;
            lock_cnt  <= lock_cnt_nxt;
            if (grant_any)
                last_grant <= grant1;
            rd_valid <= grant_read;
            if (grant_read)
                rd_port <= grant1;
        end
    end

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = grant_any;
    assign mem_write      = grant1 ? m1_write : (grant0 & m0_write);

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_valid & ~rd_port;
    assign m1_readdatavalid = rd_valid & rd_port;
endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level model of the arbitration rules and a shadow memory.
module tb_main_mem_arbiter;
    localparam int ADDR_W   = 15;
    localparam int MAX_LOCK = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
    logic [3:0]        m0_byteenable, m1_byteenable, mem_byteenable;
    logic              m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0]       m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              mem_chipselect, mem_write;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    main_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Memory with registered address and unregistered read data.
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr_q;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            addr_q <= mem_address;
            if (mem_write)
                mem[mem_address] <= merge(mem[mem_address], mem_writedata, mem_byteenable);
        end
    end
    assign mem_readdata = mem[addr_q];

    logic [31:0] shadow [0:(1<<ADDR_W)-1];

    task automatic drive_port(input int p, input logic rd, input logic wr, input logic lk,
                              input logic [ADDR_W-1:0] a, input logic [3:0] be,
                              input logic [31:0] d);
        if (p == 0) begin
            m0_read = rd; m0_write = wr; m0_lock = lk;
            m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_lock = lk;
            m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    task automatic idle_inputs;
        drive_port(0, 0, 0, 0, '0, 4'h0, 32'h0);
        drive_port(1, 0, 0, 0, '0, 4'h0, 32'h0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle_inputs();
        m0_write = 1'b1;
        m1_read  = 1'b1;
        #3;
        tests++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: cs=%b wr=%b, want 0 0", mem_chipselect, mem_write);
        end
        tests++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
            fails++;
            $display("FAIL reset_wait: wait0=%b wait1=%b, want 1 1", m0_waitrequest, m1_waitrequest);
        end
        @(posedge clk); #1;
        tests++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0) begin
            fails++;
            $display("FAIL reset_rdv: rdv0=%b rdv1=%b cs=%b, want 0 0 0",
                     m0_readdatavalid, m1_readdatavalid, mem_chipselect);
        end
        idle_inputs();
        #1;
        tests++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_wait: wait0=%b wait1=%b, want 0 0", m0_waitrequest, m1_waitrequest);
        end
    endtask

    task automatic test_contention;
        do_reset();
        drive_port(0, 0, 1, 0, 15'h0010, 4'hF, 32'hA5A5_0010);
        @(negedge clk);
        drive_port(0, 0, 0, 0, '0, 4'h0, 32'h0);
        drive_port(1, 0, 1, 0, 15'h0020, 4'hF, 32'h5A5A_0020);
        @(negedge clk);
        do_reset();
        drive_port(0, 1, 0, 0, 15'h0010, 4'h0, 32'h0);
        drive_port(1, 1, 0, 0, 15'h0020, 4'h0, 32'h0);
        #1;
        tests++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || mem_address !== 15'h0010) begin
            fails++;
            $display("FAIL contention_c0: wait0=%b wait1=%b addr=%h, want 0 1 0010",
                     m0_waitrequest, m1_waitrequest, mem_address);
        end
        @(negedge clk); #1;
        tests++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0 || mem_address !== 15'h0020) begin
            fails++;
            $display("FAIL contention_c1: wait0=%b wait1=%b addr=%h, want 1 0 0020",
                     m0_waitrequest, m1_waitrequest, mem_address);
        end
        tests++;
        if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'hA5A5_0010) begin
            fails++;
            $display("FAIL contention_rd0: rdv0=%b rdv1=%b data=%h, want 1 0 a5a50010",
                     m0_readdatavalid, m1_readdatavalid, m0_readdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 32'h5A5A_0020) begin
            fails++;
            $display("FAIL contention_rd1: rdv1=%b rdv0=%b data=%h, want 1 0 5a5a0020",
                     m1_readdatavalid, m0_readdatavalid, m1_readdata);
        end
    endtask

    task automatic test_write_read;
        do_reset();
        drive_port(1, 0, 1, 0, 15'h7FFF, 4'hF, 32'hDEAD_BEEF);
        #1;
        tests++;
        if (m1_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
            fails++;
            $display("FAIL wr_accept: wait1=%b wr=%b cs=%b, want 0 1 1", m1_waitrequest, mem_write, mem_chipselect);
        end
        @(negedge clk);
        drive_port(1, 1, 0, 0, 15'h7FFF, 4'h0, 32'h0);
        #1;
        tests++;
        if (m1_waitrequest !== 1'b0 || m1_readdatavalid !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL rd_accept: wait1=%b rdv1=%b wr=%b, want 0 0 0",
                     m1_waitrequest, m1_readdatavalid, mem_write);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL wr_rd_data: rdv1=%b data=%h, want 1 deadbeef", m1_readdatavalid, m1_readdata);
        end
    endtask

    task automatic test_byte_lanes;
        do_reset();
        drive_port(0, 0, 1, 0, 15'h0040, 4'hF, 32'h1122_3344);
        @(negedge clk);
        drive_port(0, 0, 1, 0, 15'h0040, 4'h1, 32'h0000_00AA);
        @(negedge clk);
        drive_port(0, 1, 0, 0, 15'h0040, 4'h0, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1122_33AA) begin
            fails++;
            $display("FAIL byte_lanes: rdv0=%b data=%h, want 1 112233aa", m0_readdatavalid, m0_readdata);
        end
    endtask

    task automatic test_lock;
        int m0_grants;
        int m1_wait_cycles;
        m0_grants = 0;
        m1_wait_cycles = 0;
        do_reset();
        drive_port(0, 1, 0, 1, 15'h0010, 4'h0, 32'h0);
        drive_port(1, 1, 0, 0, 15'h0020, 4'h0, 32'h0);
        for (int i = 0; i < MAX_LOCK; i++) begin
            #1;
            if (m0_waitrequest === 1'b0) m0_grants++;
            if (m1_waitrequest === 1'b1) m1_wait_cycles++;
            @(negedge clk);
        end
        #1;
        tests++;
        if (m0_grants != MAX_LOCK || m1_wait_cycles != MAX_LOCK) begin
            fails++;
            $display("FAIL lock_run: m0 grants=%0d m1 wait cycles=%0d, want %0d %0d",
                     m0_grants, m1_wait_cycles, MAX_LOCK, MAX_LOCK);
        end
        tests++;
        if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
            fails++;
            $display("FAIL lock_release: wait1=%b wait0=%b, want 0 1", m1_waitrequest, m0_waitrequest);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_read;
        do_reset();
        drive_port(1, 1, 0, 0, 15'h0020, 4'h0, 32'h0);
        #1;
        tests++;
        if (m1_waitrequest !== 1'b0) begin
            fails++;
            $display("FAIL midrd_accept: wait1=%b, want 0", m1_waitrequest);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        tests++;
        if (m1_readdatavalid !== 1'b0) begin
            fails++;
            $display("FAIL midrd_rdv: rdv1=%b, want 0", m1_readdatavalid);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive_port(0, 1, 0, 0, 15'h0010, 4'h0, 32'h0);
        drive_port(1, 1, 0, 0, 15'h0020, 4'h0, 32'h0);
        #1;
        tests++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || m1_readdatavalid !== 1'b0) begin
            fails++;
            $display("FAIL midrd_after: wait0=%b wait1=%b rdv1=%b, want 0 1 0",
                     m0_waitrequest, m1_waitrequest, m1_readdatavalid);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_idle_lock_owner;
        int waited;
        waited = 0;
        do_reset();
        drive_port(1, 1, 0, 1, 15'h0020, 4'h0, 32'h0);
        @(negedge clk);
        drive_port(1, 0, 0, 1, 15'h0020, 4'h0, 32'h0);
        drive_port(0, 1, 0, 0, 15'h0010, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (m0_waitrequest === 1'b1) waited++;
            @(negedge clk);
        end
        m1_lock = 1'b0;
        #1;
        if (m0_waitrequest === 1'b1) waited++;
        tests++;
        if (waited != 4) begin
            fails++;
            $display("FAIL idle_owner_wait: waited %0d cycles, want 4", waited);
        end
        @(negedge clk); #1;
        tests++;
        if (m0_waitrequest !== 1'b0) begin
            fails++;
            $display("FAIL idle_owner_grant: wait0=%b, want 0", m0_waitrequest);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random;
        int last, owner, cnt, pend, g;
        logic [31:0] pend_data;
        logic rd [2], wr [2], lk [2], rq [2];
        logic [ADDR_W-1:0] ad [2];
        logic [3:0] be [2];
        logic [31:0] wd [2];
        int op;

        do_reset();
        for (int a = 0; a < 16; a++) begin
            drive_port(0, 0, 1, 0, ADDR_W'(16'h0100 + a), 4'hF, 32'hC0DE_0000 + a);
            shadow[16'h0100 + a] = 32'hC0DE_0000 + a;
            @(negedge clk);
        end
        do_reset();
        last = 1; owner = -1; cnt = 0; pend = -1; pend_data = '0;

        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                op = $urandom_range(0, 4);
                rd[p] = (op == 1 || op == 3);
                wr[p] = (op == 2 || op == 4);
                lk[p] = ($urandom_range(0, 2) != 0);
                ad[p] = ADDR_W'(16'h0100 + $urandom_range(0, 15));
                be[p] = 4'($urandom_range(0, 15));
                wd[p] = $urandom;
                rq[p] = rd[p] | wr[p];
                drive_port(p, rd[p], wr[p], lk[p], ad[p], be[p], wd[p]);
            end
            #1;
            if (owner >= 0)          g = rq[owner] ? owner : -1;
            else if (rq[0] && rq[1]) g = 1 - last;
            else if (rq[0])          g = 0;
            else if (rq[1])          g = 1;
            else                     g = -1;

            tests++;
            if (m0_waitrequest !== (rq[0] && g != 0) || m1_waitrequest !== (rq[1] && g != 1)) begin
                fails++;
                $display("FAIL rand_wait c%0d: wait0=%b wait1=%b, want %b %b", c,
                         m0_waitrequest, m1_waitrequest, rq[0] && g != 0, rq[1] && g != 1);
            end
            tests++;
            if (mem_chipselect !== (g >= 0) ||
                (g >= 0 && (mem_write !== wr[g] || mem_address !== ad[g]))) begin
                fails++;
                $display("FAIL rand_mem c%0d: cs=%b wr=%b addr=%h, want grant %0d", c,
                         mem_chipselect, mem_write, mem_address, g);
            end
            tests++;
            if (m0_readdatavalid !== (pend == 0) || m1_readdatavalid !== (pend == 1) ||
                (pend >= 0 && mem_readdata !== pend_data)) begin
                fails++;
                $display("FAIL rand_rd c%0d: rdv0=%b rdv1=%b data=%h, want port %0d data %h", c,
                         m0_readdatavalid, m1_readdatavalid, mem_readdata, pend, pend_data);
            end

            pend = -1;
            if (g >= 0) begin
                if (rd[g]) begin
                    pend = g;
                    pend_data = shadow[ad[g]];
                end
                if (wr[g]) shadow[ad[g]] = merge(shadow[ad[g]], wd[g], be[g]);
                last = g;
            end
            if (owner >= 0) begin
                if (!lk[owner]) owner = -1;
                else if (g >= 0) begin
                    cnt++;
                    if (cnt >= MAX_LOCK) owner = -1;
                end
            end else if (g >= 0 && lk[g]) begin
                owner = g;
                cnt = 1;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_write_read();
        test_byte_lanes();
        test_lock();
        test_reset_mid_read();
        test_idle_lock_owner();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15: word-address width, matching the 32768-word main memory.
REQ-002 Parameter MAX_LOCK, default 16: maximum consecutive locked grants before a forced release.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 mN_address  in  ADDR_W  word address of requester N (N = 0, 1).
REQ-006 mN_byteenable  in  4  write byte lanes of requester N.
REQ-007 mN_read / mN_write  in  1 each  requests of requester N; both high at once is illegal.
REQ-008 mN_writedata  in  32  write data of requester N.
REQ-009 mN_lock  in  1  requests that the grant be kept for back-to-back accesses (read-modify-write).
REQ-010 mN_waitrequest  out  1  high while requester N's request is not accepted this cycle.
REQ-011 mN_readdata  out  32  read data returned to requester N.
REQ-012 mN_readdatavalid  out  1  qualifies mN_readdata for one cycle.
REQ-013 mem_address  out  ADDR_W  address to the memory.
REQ-014 mem_byteenable  out  4  byte enables to the memory.
REQ-015 mem_chipselect  out  1  memory access strobe.
REQ-016 mem_write  out  1  memory write strobe.
REQ-017 mem_writedata  out  32  write data to the memory.
REQ-018 mem_readdata  in  32  memory read data; valid the cycle after the address is accepted (registered address, unregistered output).

Function
REQ-019 Request: reqN = mN_read | mN_write; at most one request is granted per cycle.
REQ-020 Grant is combinational from reqN, the last_grant register and the lock state.
- A single requester is granted immediately.
- With both requesting and no lock active, grant goes to the port that is not last_grant (round-robin).
REQ-021 mN_waitrequest = reqN & ~grantN; an idle requester sees waitrequest low.
REQ-022 Memory outputs mux the granted port's address, byteenable and writedata.
- mem_chipselect = any grant; mem_write = granted port's write.
- With no grant: chipselect and write are 0, other memory outputs are don't-care.
REQ-023 On each grant, last_grant is set to the granted port index; last_grant holds when idle.
REQ-024 Read return pipeline:
- A granted read sets rd_valid = 1 and rd_port = N for the next cycle; any other cycle clears rd_valid.
- mN_readdatavalid = rd_valid & (rd_port == N).
- mN_readdata = mem_readdata; read latency is exactly 1 cycle after acceptance.
REQ-025 Back-to-back reads from alternating ports each return in order with 1-cycle latency; no bubbles are inserted.
REQ-026 Writes complete on acceptance and produce no readdatavalid.
REQ-027 Lock state machine: states UNLOCKED, LOCKED.
- UNLOCKED -> LOCKED when the granted port has mN_lock high; the owner becomes lock_port and lock_cnt is set to 1.
- In LOCKED, lock_port is granted whenever it requests; the other port is not granted even if lock_port is idle.
- On each locked grant, lock_cnt increments.
- LOCKED -> UNLOCKED when lock_port drops mN_lock, or when lock_cnt reaches MAX_LOCK.
- On a MAX_LOCK release, the next cycle arbitrates round-robin with last_grant = lock_port, so the other port wins if it is requesting.
REQ-028 lock_cnt saturates at MAX_LOCK and is 0 in UNLOCKED; its width is clog2(MAX_LOCK+1).
REQ-029 A lock asserted on a non-granted port has no effect until that port is granted.

Reset
REQ-030 While reset_n is low, asynchronously:
- last_grant = 1 (port 0 wins the first contention), rd_valid = 0, rd_port = 0, state UNLOCKED, lock_cnt = 0.
- mem_chipselect and mem_write are driven 0 regardless of requests; both mN_readdatavalid are 0.
- mN_waitrequest equals reqN.
REQ-031 A read accepted in the cycle before reset assertion produces no readdatavalid after reset release.
REQ-032 The first edge after reset_n deasserts performs normal arbitration.

Verification
REQ-033 Contention:
- Stimulus: after reset, both ports read, m0 addr 0x0010, m1 addr 0x0020, held.
- Response: m0 is granted in cycle 0 and m1 in cycle 1; m0_readdatavalid is high in cycle 1 and m1_readdatavalid in cycle 2, each with its own word.
REQ-034 Write then read:
- Stimulus: m1 writes 0xDEADBEEF to 0x7FFF with byteenable 0xF; the next cycle m1 reads 0x7FFF.
- Response: no wait states, and m1_readdata = 0xDEADBEEF one cycle after the read.
REQ-035 Byte lanes:
- Stimulus: m0 writes 0x000000AA with byteenable 0x1 over the word 0x11223344.
- Response: a subsequent read returns 0x112233AA.
REQ-036 Lock:
- Stimulus: m0 holds lock with continuous reads while m1 requests constantly, MAX_LOCK = 16.
- Response: m0 receives exactly 16 consecutive grants, then m1 is granted, and m1_waitrequest is high for all 16 prior cycles.
REQ-037 Reset mid-read:
- Stimulus: assert reset_n low in the cycle after a granted m1 read.
- Response: m1_readdatavalid is 0 immediately, and after release port 0 wins the first contention.
REQ-038 Idle lock owner:
- Stimulus: m1 locked and idle while m0 requests.
- Response: m0 stays in wait until m1 drops lock, then m0 is granted the next cycle.
